// File: rtl/stack_sequencer.sv
// Stack/PC-redirect sequencer: turns CALL, RET, RTI and external interrupts
// into fixed runs of stack micro-ops while holding the front end stalled.
module stack_sequencer #(
   parameter int unsigned VEC_ADDR = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int_sig,
   input  logic       call_req,
   input  logic       ret_req,
   input  logic       rti_req,
   output logic       stall,
   output logic       mem_we,
   output logic       mem_re,
   output logic       half_hi,
   output logic       addr_src,
   output logic [1:0] sp_op,
   output logic [1:0] pc_src,
   output logic       pc_load,
   output logic       flags_save,
   output logic       flags_restore,
   output logic       int_ack,
   output logic       done
);

   typedef enum logic [3:0] {
      IDLE,
      PUSH_HI,
      PUSH_LO,
      SAVE_F,
      VEC_HI,
      VEC_LO,
      JUMP,
      REST_F,
      POP_LO,
      POP_HI
   } state_t;

   typedef enum logic [1:0] {
      SEQ_INT,
      SEQ_CALL,
      SEQ_RET,
      SEQ_RTI
   } seq_t;

   localparam logic [1:0] SP_HOLD = 2'b00;
   localparam logic [1:0] SP_DEC  = 2'b01;
   localparam logic [1:0] SP_INC  = 2'b10;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_VECTOR = 2'b01;
   localparam logic [1:0] PC_POP    = 2'b10;
   localparam logic [1:0] PC_CALL   = 2'b11;

   // The vector fetch reads VEC_ADDR+1, so the base must leave room for it.
   if (VEC_ADDR == 32'hFFFF_FFFF) begin : g_vec_addr_check
      $error("stack_sequencer: VEC_ADDR leaves no room for the low vector half");
   end

   state_t state;
   state_t state_nxt;
   seq_t   seq;
   seq_t   seq_nxt;
   logic   int_prev;
   logic   int_pending;
   logic   int_rise;

   assign int_rise = int_sig & ~int_prev;

   // Sequencer state and the sequence type that steers the shared states.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         seq   <= SEQ_INT;
      end else begin
         state <= state_nxt;
         seq   <= seq_nxt;
      end
   end

   // A fresh edge in the acknowledge cycle must survive the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_prev    <= 1'b0;
         int_pending <= 1'b0;
      end else begin
         int_prev    <= int_sig;
         int_pending <= int_rise | (int_pending & ~int_ack);
      end
   end

   // Next-state selection and Moore output decode.
   always_comb begin
      state_nxt     = state;
      seq_nxt       = seq;
      stall         = 1'b1;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      half_hi       = 1'b0;
      addr_src      = 1'b0;
      sp_op         = SP_HOLD;
      pc_src        = PC_SEQ;
      pc_load       = 1'b0;
      flags_save    = 1'b0;
      flags_restore = 1'b0;
      int_ack       = 1'b0;
      done          = 1'b0;

      unique case (state)
         IDLE: begin
            stall = 1'b0;
            if (rti_req) begin
               state_nxt = REST_F;
               seq_nxt   = SEQ_RTI;
            end else if (ret_req) begin
               state_nxt = POP_LO;
               seq_nxt   = SEQ_RET;
            end else if (call_req) begin
               state_nxt = PUSH_HI;
               seq_nxt   = SEQ_CALL;
            end else if (int_pending) begin
               state_nxt = PUSH_HI;
               seq_nxt   = SEQ_INT;
            end
         end
         PUSH_HI: begin
            mem_we    = 1'b1;
            half_hi   = 1'b1;
            sp_op     = SP_DEC;
            int_ack   = (seq == SEQ_INT);
            state_nxt = PUSH_LO;
         end
         PUSH_LO: begin
            mem_we    = 1'b1;
            sp_op     = SP_DEC;
            state_nxt = (seq == SEQ_CALL) ? JUMP : SAVE_F;
         end
         SAVE_F: begin
            flags_save = 1'b1;
            state_nxt  = VEC_HI;
         end
         VEC_HI: begin
            mem_re    = 1'b1;
            addr_src  = 1'b1;
            half_hi   = 1'b1;
            state_nxt = VEC_LO;
         end
         VEC_LO: begin
            mem_re    = 1'b1;
            addr_src  = 1'b1;
            pc_src    = PC_VECTOR;
            pc_load   = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         JUMP: begin
            pc_src    = PC_CALL;
            pc_load   = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         REST_F: begin
            flags_restore = 1'b1;
            state_nxt     = POP_LO;
         end
         POP_LO: begin
            mem_re    = 1'b1;
            sp_op     = SP_INC;
            state_nxt = POP_HI;
         end
         POP_HI: begin
            mem_re    = 1'b1;
            half_hi   = 1'b1;
            sp_op     = SP_INC;
            pc_src    = PC_POP;
            pc_load   = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            stall     = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: walks every sequence cycle by cycle and
// compares the full packed output word against hand-derived per-state values.
module tb_stack_sequencer;

   logic       clk;
   logic       rst;
   logic       int_sig;
   logic       call_req;
   logic       ret_req;
   logic       rti_req;
   logic       stall;
   logic       mem_we;
   logic       mem_re;
   logic       half_hi;
   logic       addr_src;
   logic [1:0] sp_op;
   logic [1:0] pc_src;
   logic       pc_load;
   logic       flags_save;
   logic       flags_restore;
   logic       int_ack;
   logic       done;

   int errors = 0;
   int checks = 0;

   // Packed as {stall, we, re, half_hi, addr_src, sp_op, pc_src, load, fsave, frest, ack, done}.
   logic [13:0] obs;
   assign obs = {stall, mem_we, mem_re, half_hi, addr_src, sp_op, pc_src,
                 pc_load, flags_save, flags_restore, int_ack, done};

   localparam logic [13:0] E_IDLE     = 14'b0_0_0_0_0_00_00_0_0_0_0_0;
   localparam logic [13:0] E_PUSHHI_I = 14'b1_1_0_1_0_01_00_0_0_0_1_0;
   localparam logic [13:0] E_PUSHHI_C = 14'b1_1_0_1_0_01_00_0_0_0_0_0;
   localparam logic [13:0] E_PUSHLO   = 14'b1_1_0_0_0_01_00_0_0_0_0_0;
   localparam logic [13:0] E_SAVEF    = 14'b1_0_0_0_0_00_00_0_1_0_0_0;
   localparam logic [13:0] E_VECHI    = 14'b1_0_1_1_1_00_00_0_0_0_0_0;
   localparam logic [13:0] E_VECLO    = 14'b1_0_1_0_1_00_01_1_0_0_0_1;
   localparam logic [13:0] E_JUMP     = 14'b1_0_0_0_0_00_11_1_0_0_0_1;
   localparam logic [13:0] E_RESTF    = 14'b1_0_0_0_0_00_00_0_0_1_0_0;
   localparam logic [13:0] E_POPLO    = 14'b1_0_1_0_0_10_00_0_0_0_0_0;
   localparam logic [13:0] E_POPHI    = 14'b1_0_1_1_0_10_10_1_0_0_0_1;

   stack_sequencer #(.VEC_ADDR(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .int_sig       (int_sig),
      .call_req      (call_req),
      .ret_req       (ret_req),
      .rti_req       (rti_req),
      .stall         (stall),
      .mem_we        (mem_we),
      .mem_re        (mem_re),
      .half_hi       (half_hi),
      .addr_src      (addr_src),
      .sp_op         (sp_op),
      .pc_src        (pc_src),
      .pc_load       (pc_load),
      .flags_save    (flags_save),
      .flags_restore (flags_restore),
      .int_ack       (int_ack),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic c, input logic r, input logic t, input logic i);
      call_req = c;
      ret_req  = r;
      rti_req  = t;
      int_sig  = i;
   endtask

   task automatic checkOutput(input string tag, input logic [13:0] expected);
      checks++;
      assert (obs === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0);
      #3 rst = 1'b0;
      #1 checkOutput("reset_async", E_IDLE);
      tick();
      checkOutput("reset_held", E_IDLE);
      rst = 1'b1;
      tick();
      checkOutput("idle_after_reset", E_IDLE);

      $display("[TB] interrupt sequence");
      applyStimulus(0, 0, 0, 1);
      tick();
      checkOutput("int_edge_pending", E_IDLE);
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("int_push_hi", E_PUSHHI_I);
      tick(); checkOutput("int_push_lo", E_PUSHLO);
      tick(); checkOutput("int_save_f", E_SAVEF);
      tick(); checkOutput("int_vec_hi", E_VECHI);
      tick(); checkOutput("int_vec_lo", E_VECLO);
      tick(); checkOutput("int_back_idle", E_IDLE);

      $display("[TB] call sequence");
      applyStimulus(1, 0, 0, 0);
      tick(); checkOutput("call_push_hi", E_PUSHHI_C);
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("call_push_lo", E_PUSHLO);
      tick(); checkOutput("call_jump", E_JUMP);
      tick(); checkOutput("call_back_idle", E_IDLE);

      $display("[TB] ret and rti sequences");
      applyStimulus(0, 1, 0, 0);
      tick(); checkOutput("ret_pop_lo", E_POPLO);
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("ret_pop_hi", E_POPHI);
      tick(); checkOutput("ret_back_idle", E_IDLE);
      applyStimulus(0, 0, 1, 0);
      tick(); checkOutput("rti_rest_f", E_RESTF);
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("rti_pop_lo", E_POPLO);
      tick(); checkOutput("rti_pop_hi", E_POPHI);
      tick(); checkOutput("rti_back_idle", E_IDLE);

      $display("[TB] priority rti over call");
      applyStimulus(1, 0, 1, 0);
      tick(); checkOutput("prio_rest_f", E_RESTF);
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("prio_pop_lo", E_POPLO);
      tick(); checkOutput("prio_pop_hi", E_POPHI);
      tick(); checkOutput("prio_back_idle", E_IDLE);

      $display("[TB] call with coincident interrupt edge");
      applyStimulus(1, 0, 0, 1);
      tick(); checkOutput("coin_call_push_hi", E_PUSHHI_C);
      applyStimulus(0, 0, 0, 1);
      tick(); checkOutput("coin_call_push_lo", E_PUSHLO);
      tick(); checkOutput("coin_call_jump", E_JUMP);
      tick(); checkOutput("coin_idle_gap", E_IDLE);
      tick(); checkOutput("coin_int_push_hi", E_PUSHHI_I);
      tick(); checkOutput("coin_int_push_lo", E_PUSHLO);
      tick(); checkOutput("coin_int_save_f", E_SAVEF);
      tick(); checkOutput("coin_int_vec_hi", E_VECHI);
      tick(); checkOutput("coin_int_vec_lo", E_VECLO);
      tick(); checkOutput("coin_int_idle", E_IDLE);

      $display("[TB] int_sig held high does not retrigger");
      applyStimulus(1, 0, 0, 1);
      tick(); checkOutput("held_call_push_hi", E_PUSHHI_C);
      applyStimulus(0, 0, 0, 1);
      tick(); checkOutput("held_call_push_lo", E_PUSHLO);
      tick(); checkOutput("held_call_jump", E_JUMP);
      tick(); checkOutput("held_call_idle", E_IDLE);
      applyStimulus(0, 1, 0, 1);
      tick(); checkOutput("held_ret_pop_lo", E_POPLO);
      applyStimulus(0, 0, 0, 1);
      tick(); checkOutput("held_ret_pop_hi", E_POPHI);
      tick(); checkOutput("held_ret_idle", E_IDLE);
      tick(); checkOutput("held_no_retrigger", E_IDLE);

      $display("[TB] interrupt edge while busy");
      applyStimulus(0, 0, 0, 0);
      tick(); checkOutput("busy_low_idle", E_IDLE);
      applyStimulus(0, 1, 0, 0);
      tick(); checkOutput("busy_pop_lo", E_POPLO);
      applyStimulus(0, 0, 0, 1);
      tick(); checkOutput("busy_pop_hi", E_POPHI);
      tick(); checkOutput("busy_idle_gap", E_IDLE);
      tick(); checkOutput("busy_int_push_hi", E_PUSHHI_I);
      tick(); checkOutput("busy_int_push_lo", E_PUSHLO);

      $display("[TB] reset during save_f");
      tick(); checkOutput("rst_save_f", E_SAVEF);
      applyStimulus(0, 0, 0, 0);
      rst = 1'b0;
      #1 checkOutput("rst_mid_seq_async", E_IDLE);
      tick(); checkOutput("rst_mid_seq_held", E_IDLE);
      rst = 1'b1;
      tick(); checkOutput("rst_release_idle1", E_IDLE);
      tick(); checkOutput("rst_release_idle2", E_IDLE);
      tick(); checkOutput("rst_no_resume", E_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
